// File: rtl/astro_dificuldade_pkg.sv
// -----------------------------------------------------------------------------
// astro_dificuldade_pkg
// Shared constants for the asteroid-game difficulty scheduler:
//   - MAX_LEVELS   : upper bound on the number of difficulty levels.
//   - TAB_GERA / TAB_MOVE_ASTE / TAB_MOVE_TIRO : per-level interval tables
//     (clock cycles), used when DIFF_RAMP_EN is not defined.
//   - BASE_x / STEP_x / MIN_x : linear-ramp constants, used only when
//     DIFF_RAMP_EN is defined.
//   - nivel_idx_t  : index type wide enough to address any table entry.
// -----------------------------------------------------------------------------
package astro_dificuldade_pkg;

    localparam int MAX_LEVELS = 16;

    // Full-width table index; narrower level registers are zero-extended to it.
    typedef logic [$clog2(MAX_LEVELS)-1:0] nivel_idx_t;

    typedef logic [63:0] tab_t [MAX_LEVELS];

    // Asteroid spawn interval: 350M cycles at level 0, 20M shorter per level.
    localparam tab_t TAB_GERA = '{
        64'd350000000, 64'd330000000, 64'd310000000, 64'd290000000,
        64'd270000000, 64'd250000000, 64'd230000000, 64'd210000000,
        64'd190000000, 64'd170000000, 64'd150000000, 64'd130000000,
        64'd110000000, 64'd90000000,  64'd70000000,  64'd50000000
    };

    // Asteroid move interval: 200M cycles at level 0, 10M shorter per level.
    localparam tab_t TAB_MOVE_ASTE = '{
        64'd200000000, 64'd190000000, 64'd180000000, 64'd170000000,
        64'd160000000, 64'd150000000, 64'd140000000, 64'd130000000,
        64'd120000000, 64'd110000000, 64'd100000000, 64'd90000000,
        64'd80000000,  64'd70000000,  64'd60000000,  64'd50000000
    };

    // Shot move interval: 20M cycles at level 0, 1M shorter per level.
    localparam tab_t TAB_MOVE_TIRO = '{
        64'd20000000, 64'd19000000, 64'd18000000, 64'd17000000,
        64'd16000000, 64'd15000000, 64'd14000000, 64'd13000000,
        64'd12000000, 64'd11000000, 64'd10000000, 64'd9000000,
        64'd8000000,  64'd7000000,  64'd6000000,  64'd5000000
    };

    // Linear-ramp constants: interval = max(BASE - nivel*STEP, MIN).
    localparam logic [63:0] BASE_GERA      = 64'd100;
    localparam logic [63:0] STEP_GERA      = 64'd30;
    localparam logic [63:0] MIN_GERA       = 64'd20;
    localparam logic [63:0] BASE_MOVE_ASTE = 64'd80;
    localparam logic [63:0] STEP_MOVE_ASTE = 64'd20;
    localparam logic [63:0] MIN_MOVE_ASTE  = 64'd10;
    localparam logic [63:0] BASE_MOVE_TIRO = 64'd40;
    localparam logic [63:0] STEP_MOVE_TIRO = 64'd5;
    localparam logic [63:0] MIN_MOVE_TIRO  = 64'd8;

endpackage

// File: rtl/contador_ticks_nivel.sv
// -----------------------------------------------------------------------------
// contador_ticks_nivel
// In-level tick counter. Counts enabled cycles from 0 to LEVEL_TICKS-1, then
// wraps to 0 (advancing to the next level) or, on the last level, saturates.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (Q -> 0)
//   i_ld   : level load, clears Q
//   i_cnt  : count enable (ent && enp)
//   i_sat  : current level is the last one; the counter must not wrap
//   o_q    : tick count within the current level
//   o_fim  : end-of-level strobe; high when this edge advances the level
// -----------------------------------------------------------------------------
module contador_ticks_nivel #(
    parameter int LEVEL_TICKS = 10000,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld,
    input  logic             i_cnt,
    input  logic             i_sat,
    output logic [CNT_W-1:0] o_q,
    output logic             o_fim
);

    localparam logic [CNT_W-1:0] LAST_Q = CNT_W'(LEVEL_TICKS - 1);

    logic [CNT_W-1:0] r_q;
    logic             w_no_fim;

    assign w_no_fim = (r_q == LAST_Q);
    // Advance only when counting out of the final tick of a non-final level.
    assign o_fim    = i_cnt && w_no_fim && !i_sat;
    assign o_q      = r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= '0;
        end else if (i_cnt) begin
            if (!w_no_fim) begin
                r_q <= r_q + 1'b1;
            end else if (!i_sat) begin
                r_q <= '0;
            end
            // last tick of last level: hold (saturate)
        end
    end

endmodule

// File: rtl/contador_dificuldades_param.sv
// -----------------------------------------------------------------------------
// contador_dificuldades_param
// Parametrised difficulty scheduler for the asteroid game. Walks through
// N_LEVELS levels of LEVEL_TICKS enabled cycles each and drives the interval
// values used by the game timers.
// Optional build macro: DIFF_RAMP_EN -- intervals computed from a linear ramp
// (BASE_x/STEP_x/MIN_x) instead of the per-level tables.
// Ports:
//   clock           : system clock
//   clr             : synchronous active-high reset
//   ld              : load level from D_nivel (clamped to N_LEVELS-1)
//   ent, enp        : count enables (both needed to count; ent also gates rco)
//   D_nivel         : level to load
//   Q               : tick count within the current level
//   nivel           : current level index
//   nivel_up        : one-cycle pulse after a counted level advance
//   rco             : final level fully elapsed (combinational)
//   tempo_gera_aste : asteroid spawn interval (cycles), 1-cycle after nivel
//   tempo_move_aste : asteroid move interval (cycles), 1-cycle after nivel
//   tempo_move_tiro : shot move interval (cycles), 1-cycle after nivel
// -----------------------------------------------------------------------------
module contador_dificuldades_param
    import astro_dificuldade_pkg::*;
#(
    parameter  int N_LEVELS    = 12,
    parameter  int LEVEL_TICKS = 10000,
    parameter  int CNT_W       = 32,
    parameter  int TW          = 64,
    localparam int LVL_W       = ($clog2(N_LEVELS) < 1) ? 1 : $clog2(N_LEVELS)
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ld,
    input  logic             ent,
    input  logic             enp,
    input  logic [LVL_W-1:0] D_nivel,
    output logic [CNT_W-1:0] Q,
    output logic [LVL_W-1:0] nivel,
    output logic             nivel_up,
    output logic             rco,
    output logic [TW-1:0]    tempo_gera_aste,
    output logic [TW-1:0]    tempo_move_aste,
    output logic [TW-1:0]    tempo_move_tiro
);

    generate
        if (N_LEVELS < 2 || N_LEVELS > MAX_LEVELS) begin : g_bad_levels
            $error("contador_dificuldades_param: N_LEVELS out of range");
        end
        if (LEVEL_TICKS < 2) begin : g_bad_ticks
            $error("contador_dificuldades_param: LEVEL_TICKS must be >= 2");
        end
        if ((longint'(LEVEL_TICKS - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
            $error("contador_dificuldades_param: CNT_W too narrow for LEVEL_TICKS-1");
        end
    endgenerate

    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(N_LEVELS - 1);
    localparam logic [CNT_W-1:0] LAST_Q   = CNT_W'(LEVEL_TICKS - 1);

    logic [LVL_W-1:0] r_nivel;
    logic             r_up;
    logic [TW-1:0]    r_tempo_gera;
    logic [TW-1:0]    r_tempo_move_aste;
    logic [TW-1:0]    r_tempo_move_tiro;

    logic             w_cnt;
    logic             w_sat;
    logic             w_fim;
    logic [CNT_W-1:0] w_q;
    logic [LVL_W-1:0] w_ld_nivel;
    logic [LVL_W-1:0] w_lvl_src;
    logic [TW-1:0]    w_gera_next;
    logic [TW-1:0]    w_move_aste_next;
    logic [TW-1:0]    w_move_tiro_next;

    assign w_cnt      = ent && enp;
    assign w_sat      = (r_nivel == LAST_LVL);
    assign w_ld_nivel = (D_nivel > LAST_LVL) ? LAST_LVL : D_nivel;

    contador_ticks_nivel #(
        .LEVEL_TICKS (LEVEL_TICKS),
        .CNT_W       (CNT_W)
    ) u_ticks (
        .i_clk (clock),
        .i_rst (clr),
        .i_ld  (ld),
        .i_cnt (w_cnt),
        .i_sat (w_sat),
        .o_q   (w_q),
        .o_fim (w_fim)
    );

    // Intervals follow the level register one edge later; clr forces the
    // level-0 values on the reset edge itself.
    assign w_lvl_src = clr ? '0 : r_nivel;

`ifdef DIFF_RAMP_EN
    // max(BASE - n*STEP, MIN) without ever forming a negative difference.
    function automatic logic [TW-1:0] rampa(
        input logic [63:0]      base,
        input logic [63:0]      step,
        input logic [63:0]      minv,
        input logic [LVL_W-1:0] n
    );
        logic [TW-1:0] b;
        logic [TW-1:0] s;
        logic [TW-1:0] m;
        logic [TW-1:0] p;
        b = TW'(base);
        s = TW'(step);
        m = TW'(minv);
        p = TW'(n) * s;
        return ((b - m) > p) ? (b - p) : m;
    endfunction

    always_comb begin
        w_gera_next      = rampa(BASE_GERA,      STEP_GERA,      MIN_GERA,      w_lvl_src);
        w_move_aste_next = rampa(BASE_MOVE_ASTE, STEP_MOVE_ASTE, MIN_MOVE_ASTE, w_lvl_src);
        w_move_tiro_next = rampa(BASE_MOVE_TIRO, STEP_MOVE_TIRO, MIN_MOVE_TIRO, w_lvl_src);
    end
`else
    always_comb begin
        w_gera_next      = TW'(TAB_GERA[nivel_idx_t'(w_lvl_src)]);
        w_move_aste_next = TW'(TAB_MOVE_ASTE[nivel_idx_t'(w_lvl_src)]);
        w_move_tiro_next = TW'(TAB_MOVE_TIRO[nivel_idx_t'(w_lvl_src)]);
    end
`endif

    always_ff @(posedge clock) begin
        r_tempo_gera      <= w_gera_next;
        r_tempo_move_aste <= w_move_aste_next;
        r_tempo_move_tiro <= w_move_tiro_next;
        if (clr) begin
            r_nivel <= '0;
            r_up    <= 1'b0;
        end else if (ld) begin
            r_nivel <= w_ld_nivel;
            r_up    <= 1'b0;
        end else begin
            // w_fim already includes both enables and the last-level block.
            r_up <= w_fim;
            if (w_fim) begin
                r_nivel <= r_nivel + 1'b1;
            end
        end
    end

    assign Q               = w_q;
    assign nivel           = r_nivel;
    assign nivel_up        = r_up;
    assign rco             = ent && (r_nivel == LAST_LVL) && (w_q == LAST_Q);
    assign tempo_gera_aste = r_tempo_gera;
    assign tempo_move_aste = r_tempo_move_aste;
    assign tempo_move_tiro = r_tempo_move_tiro;

endmodule

// File: tb/tb_contador_dificuldades_param.sv
module tb_contador_dificuldades_param;
  import astro_dificuldade_pkg::*;

  localparam int N  = 4;
  localparam int T  = 5;
  localparam int CW = 8;
  localparam int TW = 64;

  // ---------------- clock / reset block ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT A: N=4, T=5 ----------------
  logic           clr, ld, ent, enp;
  logic [1:0]     D_nivel;
  logic [CW-1:0]  Q;
  logic [1:0]     nivel;
  logic           nivel_up, rco;
  logic [TW-1:0]  tempo_gera_aste, tempo_move_aste, tempo_move_tiro;

  contador_dificuldades_param #(
    .N_LEVELS(N), .LEVEL_TICKS(T), .CNT_W(CW), .TW(TW)
  ) dut (
    .clock(clock), .clr(clr), .ld(ld), .ent(ent), .enp(enp), .D_nivel(D_nivel),
    .Q(Q), .nivel(nivel), .nivel_up(nivel_up), .rco(rco),
    .tempo_gera_aste(tempo_gera_aste), .tempo_move_aste(tempo_move_aste),
    .tempo_move_tiro(tempo_move_tiro)
  );

  // ---------------- DUT B: N=5 (LVL_W=3), T=3 ----------------
  logic        b_clr, b_ld, b_ent, b_enp;
  logic [2:0]  b_d;
  logic [3:0]  b_q;
  logic [2:0]  b_nivel;
  logic        b_up, b_rco;
  logic [31:0] b_tg, b_ta, b_tt;

  contador_dificuldades_param #(
    .N_LEVELS(5), .LEVEL_TICKS(3), .CNT_W(4), .TW(32)
  ) dut_b (
    .clock(clock), .clr(b_clr), .ld(b_ld), .ent(b_ent), .enp(b_enp), .D_nivel(b_d),
    .Q(b_q), .nivel(b_nivel), .nivel_up(b_up), .rco(b_rco),
    .tempo_gera_aste(b_tg), .tempo_move_aste(b_ta), .tempo_move_tiro(b_tt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State is the total number of counted ticks since level 0; level and
  // in-level count are derived by division, saturating at N*T-1.
  int m_elapsed = 0;
  bit m_up = 0;
  int m_tempo_lvl = 0;  // level whose intervals are currently presented

  function automatic logic [63:0] interval(input int which, input int lvl);
`ifdef DIFF_RAMP_EN
    longint base, stp, mn;
    case (which)
      0: begin base = BASE_GERA;      stp = STEP_GERA;      mn = MIN_GERA;      end
      1: begin base = BASE_MOVE_ASTE; stp = STEP_MOVE_ASTE; mn = MIN_MOVE_ASTE; end
      default: begin base = BASE_MOVE_TIRO; stp = STEP_MOVE_TIRO; mn = MIN_MOVE_TIRO; end
    endcase
    if (lvl * stp < base - mn) return 64'(base - lvl * stp);
    return 64'(mn);
`else
    case (which)
      0: return TAB_GERA[lvl];
      1: return TAB_MOVE_ASTE[lvl];
      default: return TAB_MOVE_TIRO[lvl];
    endcase
`endif
  endfunction

  task automatic model_edge();
    int old_lvl, nxt;
    old_lvl = m_elapsed / T;
    if (clr) begin
      m_elapsed = 0;
      m_up = 0;
      m_tempo_lvl = 0;
    end else begin
      m_tempo_lvl = old_lvl;
      if (ld) begin
        m_elapsed = ((int'(D_nivel) > N - 1) ? N - 1 : int'(D_nivel)) * T;
        m_up = 0;
      end else if (ent && enp) begin
        nxt = (m_elapsed + 1 > N * T - 1) ? N * T - 1 : m_elapsed + 1;
        m_up = (nxt / T) != old_lvl;
        m_elapsed = nxt;
      end else begin
        m_up = 0;
      end
    end
  endtask

  task automatic check_all();
    exp_q.delete();
    exp_q.push_back(64'(m_elapsed % T));
    exp_q.push_back(64'(m_elapsed / T));
    exp_q.push_back(64'(m_up));
    exp_q.push_back(64'(ent && (m_elapsed == N * T - 1)));
    exp_q.push_back(interval(0, m_tempo_lvl));
    exp_q.push_back(interval(1, m_tempo_lvl));
    exp_q.push_back(interval(2, m_tempo_lvl));
    check_eq("Q",               64'(Q),          exp_q.pop_front());
    check_eq("nivel",           64'(nivel),      exp_q.pop_front());
    check_eq("nivel_up",        64'(nivel_up),   exp_q.pop_front());
    check_eq("rco",             64'(rco),        exp_q.pop_front());
    check_eq("tempo_gera_aste", tempo_gera_aste, exp_q.pop_front());
    check_eq("tempo_move_aste", tempo_move_aste, exp_q.pop_front());
    check_eq("tempo_move_tiro", tempo_move_tiro, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic c, input logic l, input logic e, input logic p,
                      input logic [1:0] d);
    clr = c; ld = l; ent = e; enp = p; D_nivel = d;
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 1, 2'd0);
  endtask

  task automatic step_b(input logic c, input logic l, input logic e, input logic [2:0] d);
    b_clr = c; b_ld = l; b_ent = e; b_enp = 1'b1; b_d = d;
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1; ld = 0; ent = 0; enp = 0; D_nivel = 0;
    b_clr = 1; b_ld = 0; b_ent = 0; b_enp = 0; b_d = 0;
    #2;

    // Reset and first advance
    step(1, 0, 0, 0, 2'd0);
    check_eq("reset_gera_lvl0", tempo_gera_aste, interval(0, 0));
    run(4);
    check_eq("pre_adv_nivel", 64'(nivel), 64'd0);
    run(1);
    check_eq("adv_nivel", 64'(nivel), 64'd1);
    check_eq("adv_up", 64'(nivel_up), 64'd1);
    run(1);
    check_eq("adv_up_once", 64'(nivel_up), 64'd0);
    check_eq("move_aste_lvl1", tempo_move_aste, interval(1, 1));

    // Saturation
    step(1, 0, 0, 0, 2'd0);
    run(20);
    check_eq("sat_nivel", 64'(nivel), 64'd3);
    check_eq("sat_q", 64'(Q), 64'd4);
    check_eq("sat_rco", 64'(rco), 64'd1);
    run(3);
    check_eq("sat_no_up", 64'(nivel_up), 64'd0);
    step(0, 0, 0, 1, 2'd0);
    check_eq("rco_gated", 64'(rco), 64'd0);
    check_eq("sat_hold_q", 64'(Q), 64'd4);

    // Enable gating: enp low every other cycle
    step(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, (i % 2) == 0, 2'd0);
    check_eq("gate_nivel", 64'(nivel), 64'd1);
    check_eq("gate_q", 64'(Q), 64'd0);

    // Load at Q=3
    step(1, 0, 0, 0, 2'd0);
    run(3);
    step(0, 1, 1, 1, 2'd2);
    check_eq("ld_nivel", 64'(nivel), 64'd2);
    check_eq("ld_q", 64'(Q), 64'd0);
    check_eq("ld_up", 64'(nivel_up), 64'd0);
    step(0, 0, 0, 0, 2'd0);
    check_eq("ld_tiro_lvl2", tempo_move_tiro, interval(2, 2));

    // clr and ld together
    step(1, 1, 1, 1, 2'd2);
    check_eq("clr_over_ld", 64'(nivel), 64'd0);

    // ld coincident with a level-advance edge
    run(4);
    step(0, 1, 1, 1, 2'd3);
    check_eq("ld_on_adv_nivel", 64'(nivel), 64'd3);
    check_eq("ld_on_adv_up", 64'(nivel_up), 64'd0);

    // clr during a nivel_up cycle
    step(1, 0, 0, 0, 2'd0);
    run(5);
    check_eq("pulse_before_clr", 64'(nivel_up), 64'd1);
    step(1, 0, 1, 1, 2'd0);
    check_eq("pulse_cleared", 64'(nivel_up), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
           2'($urandom_range(0, 3)));
    end

    // DUT B: out-of-range load clamps to the last level
    step_b(1, 0, 0, 3'd0);
    check_eq("b_reset_nivel", 64'(b_nivel), 64'd0);
    step_b(0, 1, 1, 3'b111);
    check_eq("b_clamp_nivel", 64'(b_nivel), 64'd4);
    check_eq("b_clamp_q", 64'(b_q), 64'd0);
    step_b(0, 0, 1, 3'd0);
    step_b(0, 0, 1, 3'd0);
    check_eq("b_q2", 64'(b_q), 64'd2);
    check_eq("b_rco", 64'(b_rco), 64'd1);
    step_b(0, 0, 1, 3'd0);
    check_eq("b_sat_nivel", 64'(b_nivel), 64'd4);
    check_eq("b_sat_up", 64'(b_up), 64'd0);
    step_b(0, 1, 0, 3'd3);
    check_eq("b_ld3", 64'(b_nivel), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
